// File: rtl/vga_pkg.sv
// Shared VGA raster constants (640x480 @ 60 Hz defaults), coordinate type and a
// window-decode helper used by the timing generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int   DEF_H_VISIBLE  = 640;
    localparam int   DEF_H_FRONT    = 16;
    localparam int   DEF_H_SYNC     = 96;
    localparam int   DEF_H_BACK     = 48;
    localparam int   DEF_V_VISIBLE  = 480;
    localparam int   DEF_V_FRONT    = 10;
    localparam int   DEF_V_SYNC     = 2;
    localparam int   DEF_V_BACK     = 33;
    localparam logic DEF_SYNC_POL   = 1'b0;
    localparam int   DEF_PIPE_DELAY = 2;

    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    // Half-open window test lo <= v < hi at coordinate width.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay.sv
// Fixed-depth shift register with a per-bit reset value; DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_r [DEPTH];

        // Shift chain; stage 0 captures the input each cycle.
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_r[i] <= rst_val;
                end
            end else begin
                stage_r[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign dout = stage_r[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with a registered decode of position,
// sync and display-enable, delayed sync copies, and line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE  = DEF_H_VISIBLE,
    parameter int   H_FRONT    = DEF_H_FRONT,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BACK     = DEF_H_BACK,
    parameter int   V_VISIBLE  = DEF_V_VISIBLE,
    parameter int   V_FRONT    = DEF_V_FRONT,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BACK     = DEF_V_BACK,
    parameter logic SYNC_POL   = DEF_SYNC_POL,
    parameter int   PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_LO    = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_LO    = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOT > 32'd1024 || V_TOT > 32'd1024) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    coord_t     hc_r;
    coord_t     vc_r;
    logic       blank_s;
    logic       hs_s;
    logic       vs_s;
    logic       line_start_s;
    logic       frame_start_s;
    logic       first_frame_r;
    logic [2:0] delayed_s;

    // Raster counters: vertical advances only on the horizontal wrap.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (hc_r == H_LAST) begin
            hc_r <= 10'd0;
            if (vc_r == V_LAST) begin
                vc_r <= 10'd0;
            end else begin
                vc_r <= vc_r + 10'd1;
            end
        end else begin
            hc_r <= hc_r + 10'd1;
        end
    end

    // Decode of the current counter position.
    always_comb begin
        blank_s       = (hc_r < H_VIS) && (vc_r < V_VIS);
        hs_s          = in_window(hc_r, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
        vs_s          = in_window(vc_r, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
        line_start_s  = (hc_r == 10'd0);
        frame_start_s = line_start_s && (vc_r == 10'd0);
    end

    // Output registers; the first frame after reset is not counted as completed.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX         <= 10'd0;
            DrawY         <= 10'd0;
            blank         <= 1'b0;
            hs            <= ~SYNC_POL;
            vs            <= ~SYNC_POL;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            frame_count   <= 8'd0;
            first_frame_r <= 1'b1;
        end else begin
            DrawX       <= hc_r;
            DrawY       <= vc_r;
            blank       <= blank_s;
            hs          <= hs_s;
            vs          <= vs_s;
            line_start  <= line_start_s;
            frame_start <= frame_start_s;
            if (frame_start_s) begin
                first_frame_r <= 1'b0;
                if (!first_frame_r) begin
                    frame_count <= frame_count + 8'd1;
                end else begin
                    frame_count <= frame_count;
                end
            end else begin
                frame_count   <= frame_count;
                first_frame_r <= first_frame_r;
            end
        end
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .rst_val ({~SYNC_POL, ~SYNC_POL, 1'b0}),
        .din     ({hs, vs, blank}),
        .dout    (delayed_s)
    );

    assign {hs_d, vs_d, blank_d} = delayed_s;

endmodule
